// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and the single-cycle ALU function shared by alu_seq.
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_AND = 3'd3,
                         OP_OR = 3'd4, OP_XOR = 3'd5, OP_DIV = 3'd6, OP_ILL = 3'd7;
  localparam int MAX_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  // Callers truncate to 2*WIDTH bits, which also makes SUB wrap modulo 2^(2*WIDTH).
  function automatic logic [2*MAX_W-1:0] alu_op(input logic [2:0] op, input logic [MAX_W-1:0] a, b);
    logic [2*MAX_W-1:0] xa, xb;
    xa = {{MAX_W{1'b0}}, a};
    xb = {{MAX_W{1'b0}}, b};
    return op == OP_ADD ? xa + xb :
           op == OP_SUB ? xa - xb :
           op == OP_AND ? xa & xb :
           op == OP_OR  ? xa | xb :
           op == OP_XOR ? xa ^ xb : '0;
  endfunction
endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: WIDTH-step shift-add multiplier / restoring divider sharing one register pair and adder.
module alu_iter_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] res
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, cur_hi, cur_lo, cur_b;
  logic mode_q, mode_d, busy_q, busy_d, done_q, done_d, q_bit, step, last;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] x, y, sum;
  // The first step is taken straight from the inputs on start, so WIDTH steps end WIDTH-1 edges later.
  always_comb begin
    cur_hi = start ? '0 : hi_q;
    cur_lo = start ? a : lo_q;
    cur_b = start ? b : b_q;
    mode_d = start ? mode : mode_q;
    b_d = cur_b;
    x = mode_d ? {cur_hi, cur_lo[WIDTH-1]} : {1'b0, cur_hi};
    y = (mode_d | cur_lo[0]) ? {1'b0, cur_b} : '0;
    sum = mode_d ? x - y : x + y;
    q_bit = ~sum[WIDTH];
    step = start | busy_q;
    hi_d = !step ? hi_q : mode_d ? (q_bit ? sum[WIDTH-1:0] : x[WIDTH-1:0]) : sum[WIDTH:1];
    lo_d = !step ? lo_q : mode_d ? {cur_lo[WIDTH-2:0], q_bit} : {sum[0], cur_lo[WIDTH-1:1]};
    last = busy_q && cnt_q == CW'(WIDTH - 1);
    busy_d = start | (busy_q & ~last);
    done_d = last;
    cnt_d = start ? CW'(1) : last ? '0 : busy_q ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q <= '0;
      mode_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q <= b_d;
      mode_q <= mode_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
    end
  end
  assign done = done_q;
  assign res = {hi_q, lo_q};
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; single-cycle ops finish in one cycle, MUL/DIV run through the iterative unit.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  input  logic [2:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               err
);
  state_t state_q, state_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, zero_q, zero_d, err_q, err_d;
  logic start, is_div, is_md, md_done;
  logic [2*WIDTH-1:0] result_q, result_d, md_res, fast_res;
  always_comb begin
    is_div = opcode == OP_DIV;
    is_md = opcode == OP_MUL || (is_div && operand_b != '0);
    fast_res = is_div ? {operand_a, {WIDTH{1'b1}}}
                      : (2*WIDTH)'(alu_op(opcode, MAX_W'(operand_a), MAX_W'(operand_b)));
    start = state_q == IDLE && in_valid && is_md;
    state_d = state_q;
    in_ready_d = in_ready_q;
    out_valid_d = out_valid_q;
    result_d = result_q;
    zero_d = zero_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = is_md ? BUSY : DONE;
        in_ready_d = 1'b0;
        if (!is_md) begin
          out_valid_d = 1'b1;
          result_d = fast_res;
          zero_d = fast_res == '0;
          err_d = opcode == OP_ILL || is_div;
        end
      end
      BUSY: if (md_done) begin
        state_d = DONE;
        out_valid_d = 1'b1;
        result_d = md_res;
        zero_d = md_res == '0;
        err_d = 1'b0;
      end
      DONE: if (out_ready) begin
        state_d = IDLE;
        out_valid_d = 1'b0;
        in_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      result_q <= '0;
      zero_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      zero_q <= zero_d;
      err_q <= err_d;
    end
  end
  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .mode (is_div),
    .a    (operand_a),
    .b    (operand_b),
    .done (md_done),
    .res  (md_res)
  );
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign zero = zero_q;
  assign err = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq at WIDTH=8.
module tb_alu_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [2:0] op = '0;
  logic in_ready, out_valid, zero, err;
  logic [15:0] result;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .operand_a(a),
    .operand_b(b),
    .opcode   (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .err      (err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic accept(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_res(input string tag, input logic [15:0] er, input logic ez, input logic ee, input int el);
    int lat = 1;
    logic rdy = 1'b0;
    while (!out_valid && lat < 40) begin
      rdy |= in_ready;
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_lat"}, lat, el);
    check({tag, "_rdy_busy"}, {31'b0, rdy | in_ready}, 0);
    check({tag, "_res"}, {16'b0, result}, {16'b0, er});
    check({tag, "_zero"}, {31'b0, zero}, {31'b0, ez});
    check({tag, "_err"}, {31'b0, err}, {31'b0, ee});
  endtask
  task automatic release_res(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_ovalid_drop"}, {31'b0, out_valid}, 0);
    check({tag, "_rdy_back"}, {31'b0, in_ready}, 1);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 1);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 0);
    check({tag, "_result"}, {16'b0, result}, 0);
    check({tag, "_zero"}, {31'b0, zero}, 0);
    check({tag, "_err"}, {31'b0, err}, 0);
  endtask
  initial begin
    #12 check_reset("rst0");
    rst = 1'b0;
    @(posedge clk);
    #1 accept(3'd0, 8'd200, 8'd100);
    wait_res("add", 16'h012C, 1'b0, 1'b0, 1);
    release_res("add");
    accept(3'd1, 8'd3, 8'd5);
    wait_res("sub", 16'hFFFE, 1'b0, 1'b0, 1);
    release_res("sub");
    op = 3'd2;
    a = 8'd255;
    b = 8'd255;
    in_valid = 1'b1;
    @(posedge clk);
    #1 op = 3'd0;
    a = 8'd7;
    b = 8'd8;
    wait_res("mul", 16'hFE01, 1'b0, 1'b0, 9);
    release_res("mul");
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_res("held_add", 16'h000F, 1'b0, 1'b0, 1);
    release_res("held_add");
    accept(3'd6, 8'd100, 8'd7);
    wait_res("div", 16'h020E, 1'b0, 1'b0, 9);
    release_res("div");
    accept(3'd6, 8'd10, 8'd0);
    wait_res("div0", 16'h0AFF, 1'b0, 1'b1, 1);
    release_res("div0");
    accept(3'd5, 8'hF0, 8'hFF);
    wait_res("xor", 16'h000F, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("bp_valid", {31'b0, out_valid}, 1);
      check("bp_res", {16'b0, result}, 32'h000F);
    end
    release_res("xor");
    accept(3'd7, 8'h12, 8'h34);
    wait_res("ill", 16'h0000, 1'b1, 1'b1, 1);
    release_res("ill");
    accept(3'd3, 8'h0F, 8'hF0);
    wait_res("and", 16'h0000, 1'b1, 1'b0, 1);
    release_res("and");
    accept(3'd2, 8'd17, 8'd13);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset("rst_mid");
    #3 rst = 1'b0;
    @(posedge clk);
    #1 accept(3'd2, 8'd17, 8'd13);
    wait_res("mul2", 16'h00DD, 1'b0, 1'b0, 9);
    release_res("mul2");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
